// File: rtl/soc_mem_pkg.sv
// Shared types and constants for the SoC data-memory responder.
package soc_mem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned CntWidth = 4;

  function automatic int unsigned strb_width(int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/mem_sp_ram.sv
// Byte-enabled single-port array with synchronous write and registered read.
module mem_sp_ram
  import soc_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned DATA_WIDTH = 32,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Contents are deliberately not reset; rdata_q only moves on a read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(STRB_WIDTH); i++) begin
        if (wstrb[i]) begin
          mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    if (rd_en) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one request at a time and answers with a
// one-cycle response pulse a fixed LATENCY cycles after acceptance.
module data_mem_responder
  import soc_mem_pkg::*;
#(
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LATENCY    = 2,
  localparam int unsigned ADDR_WIDTH = $clog2(MEM_DEPTH),
  localparam int unsigned STRB_WIDTH = strb_width(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [STRB_WIDTH-1:0] wstrb,
  output logic                  valid_data,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  resp_we,
  output logic                  resp_err
);

  localparam logic [ADDR_WIDTH:0] DepthExt = (ADDR_WIDTH + 1)'(MEM_DEPTH);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  we_q, err_q;
  logic                  req_ready_q, valid_data_q;
  logic                  resp_we_q, resp_err_q, resp_zero_q;
  logic [DATA_WIDTH-1:0] word_q;

  logic                  accept;
  logic                  in_range;
  logic                  req_we, req_err;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign accept   = req_valid & req_ready_q;
  assign in_range = {1'b0, addr} < DepthExt;

  mem_sp_ram #(
    .MEM_DEPTH (MEM_DEPTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (clk),
    .wr_en(accept & we & in_range),
    .rd_en(accept & ~we & in_range),
    .addr (addr),
    .wdata(wdata),
    .wstrb(wstrb),
    .rdata(ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_d = StWait;
            cnt_d   = CntWidth'(LATENCY - 1);
          end else begin
            state_d = StResp;
          end
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CntWidth'(1)) begin
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // With LATENCY=1 the response is loaded at the acceptance edge itself,
  // before we_q/err_q have captured the request.
  assign req_we  = (state_q == StIdle) ? we : we_q;
  assign req_err = (state_q == StIdle) ? ~in_range : err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      req_ready_q  <= 1'b0;
      valid_data_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_zero_q  <= 1'b1;
      word_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= (state_d == StIdle);
      valid_data_q <= (state_d == StResp);
      if (accept) begin
        we_q  <= we;
        err_q <= ~in_range;
      end
      if (state_d == StResp) begin
        resp_we_q   <= req_we;
        resp_err_q  <= req_err;
        resp_zero_q <= req_we | req_err;
        word_q      <= ram_rdata;
      end
    end
  end

  // For LATENCY=1 the array's read register already lines up with the pulse
  // and only changes on the next accepted read, so it doubles as the holder.
  assign req_ready  = req_ready_q;
  assign valid_data = valid_data_q;
  assign resp_we    = resp_we_q;
  assign resp_err   = resp_err_q;
  assign rdata      = resp_zero_q ? '0 : ((LATENCY == 1) ? ram_rdata : word_q);

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomised self-checking bench for data_mem_responder: three instances
// (64/L2, 64/L1, 48/L2) checked against a word-array reference model.
module tb_data_mem_responder;

  localparam int N = 3;

  function automatic int lat_of(int k);
    return (k == 1) ? 1 : 2;
  endfunction

  function automatic int depth_of(int k);
    return (k == 2) ? 48 : 64;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst        [N];
  logic        req_valid  [N];
  logic        req_ready  [N];
  logic        we         [N];
  logic [5:0]  addr       [N];
  logic [31:0] wdata      [N];
  logic [3:0]  wstrb      [N];
  logic        valid_data [N];
  logic [31:0] rdata      [N];
  logic        resp_we    [N];
  logic        resp_err   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    data_mem_responder #(
      .MEM_DEPTH (depth_of(g)),
      .DATA_WIDTH(32),
      .LATENCY   (lat_of(g))
    ) u_dut (
      .clk       (clk),
      .reset     (rst[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .we        (we[g]),
      .addr      (addr[g]),
      .wdata     (wdata[g]),
      .wstrb     (wstrb[g]),
      .valid_data(valid_data[g]),
      .rdata     (rdata[g]),
      .resp_we   (resp_we[g]),
      .resp_err  (resp_err[g])
    );
  end

  logic [31:0] model_mem [N][64];
  int          exp_pulses [N];
  int          pulses     [N];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (valid_data[k] === 1'b1) pulses[k]++;
    end
  end

  // Reference model: returns expected rdata and updates the word array.
  task automatic model_apply(input int k, input bit w, input logic [5:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             output logic [31:0] exp_rd, output bit exp_err);
    exp_err = (int'(a) >= depth_of(k));
    if (w && !exp_err) begin
      for (int b = 0; b < 4; b++) begin
        if (s[b]) model_mem[k][a][8*b +: 8] = d[8*b +: 8];
      end
    end
    exp_rd = (w || exp_err) ? 32'h0 : model_mem[k][a];
  endtask

  // Called at a negedge; returns at the negedge of cycle T+LATENCY+1.
  task automatic do_req(input int k, input bit w, input logic [5:0] a, input logic [31:0] d,
                        input logic [3:0] s, input bit hold, output logic [31:0] got);
    int          n;
    int          lat;
    bit          was_held;
    logic [31:0] exp_rd;
    bit          exp_err;
    lat      = lat_of(k);
    n        = 0;
    got      = 'x;
    was_held = (req_valid[k] === 1'b1);
    req_valid[k] = 1'b1;
    we[k]        = w;
    addr[k]      = a;
    wdata[k]     = d;
    wstrb[k]     = s;
    while (req_ready[k] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_in_budget", 32'(n < 20), 32'd1);
    if (n >= 20) begin
      req_valid[k] = 1'b0;
      return;
    end
    if (was_held) check_eq("back_to_back_wait", 32'(n), 32'd0);
    @(posedge clk);
    model_apply(k, w, a, d, s, exp_rd, exp_err);
    exp_pulses[k]++;
    @(negedge clk);
    if (!hold) req_valid[k] = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      check_eq("busy_ready", 32'(req_ready[k]), 32'd0);
      check_eq("valid_timing", 32'(valid_data[k]), 32'(c == lat));
      if (c == lat) begin
        check_eq("resp_rdata", rdata[k], exp_rd);
        check_eq("resp_we", 32'(resp_we[k]), 32'(w));
        check_eq("resp_err", 32'(resp_err[k]), 32'(exp_err));
        got = rdata[k];
      end
      @(negedge clk);
    end
    check_eq("ready_again", 32'(req_ready[k]), 32'd1);
    check_eq("valid_one_cycle", 32'(valid_data[k]), 32'd0);
    check_eq("rdata_hold", rdata[k], exp_rd);
  endtask

  task automatic check_idle_outputs(input int k, input logic exp_ready);
    check_eq("idle_ready", 32'(req_ready[k]), 32'(exp_ready));
    check_eq("idle_valid", 32'(valid_data[k]), 32'd0);
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] dummy_rd;
    bit          dummy_err;
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1;
      req_valid[k] = 1'b0;
      we[k] = 1'b0;
      addr[k] = '0;
      wdata[k] = '0;
      wstrb[k] = '0;
      exp_pulses[k] = 0;
      pulses[k] = 0;
    end

    // Reset held for 3 cycles: every output low.
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        check_eq("rst_ready", 32'(req_ready[k]), 32'd0);
        check_eq("rst_valid", 32'(valid_data[k]), 32'd0);
        check_eq("rst_rdata", rdata[k], 32'd0);
        check_eq("rst_resp_we", 32'(resp_we[k]), 32'd0);
        check_eq("rst_resp_err", 32'(resp_err[k]), 32'd0);
      end
    end
    for (int k = 0; k < N; k++) rst[k] = 1'b0;
    @(negedge clk);
    for (int k = 0; k < N; k++) check_idle_outputs(k, 1'b1);
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) check_idle_outputs(k, 1'b1);
    end

    // Fill every in-range word so later reads are defined.
    for (int k = 0; k < N; k++) begin
      for (int a = 0; a < depth_of(k); a++) begin
        do_req(k, 1'b1, 6'(a), $urandom, 4'hF, 1'b0, got);
      end
    end

    // Full and partial writes on the LATENCY=2 instance.
    do_req(0, 1'b1, 6'd5, 32'hDEADBEEF, 4'hF, 1'b0, got);
    check_eq("write_rdata_zero", got, 32'h0);
    do_req(0, 1'b0, 6'd5, 32'h0, 4'h0, 1'b0, got);
    check_eq("read_full_word", got, 32'hDEADBEEF);
    do_req(0, 1'b1, 6'd5, 32'h00001234, 4'b0011, 1'b0, got);
    do_req(0, 1'b0, 6'd5, 32'h0, 4'h0, 1'b0, got);
    check_eq("read_partial_word", got, 32'hDEAD1234);

    // req_valid held high: alternating reads of addr 1 and 2.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 6; i++) begin
        do_req(k, 1'b0, (i % 2 == 0) ? 6'd1 : 6'd2, 32'h0, 4'h0, 1'b1, got);
      end
      req_valid[k] = 1'b0;
      @(negedge clk);
    end

    // Out-of-range access on the 48-word instance.
    do_req(2, 1'b1, 6'd50, 32'hFFFFFFFF, 4'hF, 1'b0, got);
    do_req(2, 1'b0, 6'd50, 32'h0, 4'h0, 1'b0, got);
    check_eq("oor_read_zero", got, 32'h0);
    for (int a = 0; a < 48; a++) begin
      do_req(2, 1'b0, 6'(a), 32'h0, 4'h0, 1'b0, got);
    end

    // Reset one cycle after acceptance: first a write, then a read.
    for (int i = 0; i < 2; i++) begin
      req_valid[0] = 1'b1;
      we[0]        = (i == 0);
      addr[0]      = (i == 0) ? 6'd9 : 6'd7;
      wdata[0]     = 32'hA5A55A5A;
      wstrb[0]     = 4'hF;
      check_eq("abort_ready_pre", 32'(req_ready[0]), 32'd1);
      @(posedge clk);
      model_apply(0, (i == 0), addr[0], wdata[0], wstrb[0], dummy_rd, dummy_err);
      @(negedge clk);
      req_valid[0] = 1'b0;
      rst[0] = 1'b1;
      #1;
      check_eq("abort_valid", 32'(valid_data[0]), 32'd0);
      check_eq("abort_ready", 32'(req_ready[0]), 32'd0);
      @(negedge clk);
      check_eq("abort_valid_hold", 32'(valid_data[0]), 32'd0);
      rst[0] = 1'b0;
      @(negedge clk);
      check_idle_outputs(0, 1'b1);
    end
    do_req(0, 1'b0, 6'd9, 32'h0, 4'h0, 1'b0, got);
    check_eq("abort_write_kept", got, 32'hA5A55A5A);
    do_req(0, 1'b0, 6'd5, 32'h0, 4'h0, 1'b0, got);
    check_eq("pre_reset_data_kept", got, 32'hDEAD1234);

    // Randomised traffic across all instances.
    for (int i = 0; i < 200; i++) begin
      int k;
      k = $urandom_range(0, 2);
      do_req(k, 1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
             4'($urandom_range(0, 15)), 1'b0, got);
    end

    repeat (4) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check_eq("pulse_count", 32'(pulses[k]), 32'(exp_pulses[k]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
